kf8259_in_service_sequencer: RTL and testbench

- Clocked priority arbiter and in-service register (ISR) sequencer for the 8259A core.
- Selects the winning IR level from the request register, presents it to the control logic, and latches it into the ISR on acknowledge.
- Clears ISR bits on EOI and holds the priority rotation state.
- Sits between the IRR/IMR block and the control logic. Drives the control logic's `interrupt` and `highest_level_in_service` inputs.

---
 rtl/kf8259_in_service_sequencer.sv | 154 +++++++++++++++
 tb/tb_kf8259_in_service_sequencer.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/kf8259_in_service_sequencer.sv
// 8259A priority resolver and in-service register sequencer: IDLE -> RESOLVE -> PRESENT.
// Optional KF8259_AUTO_ROTATE_EN adds auto_rotate_mode (EOI of a single level rotates priority to it).
module kf8259_in_service_sequencer #(
    parameter logic [2:0] ROT_RESET = 3'd7
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] interrupt_request_register,
    input  logic [7:0] interrupt_mask,
    input  logic       special_mask_mode,
    input  logic       special_fully_nest_config,
    input  logic       freeze,
    input  logic       latch_in_service,
    input  logic [7:0] end_of_interrupt,
    input  logic       rotate_load,
    input  logic [2:0] priority_rotate,
`ifdef KF8259_AUTO_ROTATE_EN
    input  logic       auto_rotate_mode,
`endif
    output logic [7:0] interrupt,
    output logic       interrupt_valid,
    output logic [7:0] in_service_register,
    output logic [7:0] highest_level_in_service
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_RESOLVE = 2'd1;
    localparam logic [1:0] S_PRESENT = 2'd2;

    logic [1:0] state_q, state_d;
    logic [7:0] int_q, int_d;
    logic       vld_q, vld_d;
    logic [7:0] isr_q, isr_d;
    logic [2:0] rot_q, rot_d;

    logic [2:0] rsh;
    logic [7:0] req, eff_isr, req_r, eff_r, blk_h, allow_r, elig_r;
    logic [7:0] eligible, winner, isr_r;

    function automatic logic [7:0] ror8(input logic [7:0] v, input logic [2:0] n);
        logic [15:0] t;
        t = {v, v} >> n;
        return t[7:0];
    endfunction

    function automatic logic [7:0] rol8(input logic [7:0] v, input logic [2:0] n);
        logic [15:0] t;
        t = {v, v} << n;
        return t[15:8];
    endfunction

    // Rotated domain: bit 0 is the highest-priority level (rot+1), so "lowest set bit" wins.
    always_comb begin
        rsh     = rot_q + 3'd1;
        req     = interrupt_request_register & ~interrupt_mask;
        eff_isr = isr_q & ~(special_mask_mode ? interrupt_mask : 8'h00);
        req_r   = ror8(req, rsh);
        eff_r   = ror8(eff_isr, rsh);
        blk_h   = eff_r & (~eff_r + 8'd1);
        // blk_h-1 covers all strictly-higher levels; becomes all ones when nothing is in service.
        allow_r = (blk_h - 8'd1) | (special_fully_nest_config ? blk_h : 8'h00);
        elig_r  = req_r & allow_r;
        eligible = rol8(elig_r, rsh);
        winner   = rol8(elig_r & (~elig_r + 8'd1), rsh);
        isr_r    = ror8(isr_q, rsh);
        highest_level_in_service = rol8(isr_r & (~isr_r + 8'd1), rsh);
    end

`ifdef KF8259_AUTO_ROTATE_EN
    logic [7:0] eoi_hit;
    logic [2:0] eoi_idx;
    always_comb begin
        eoi_hit = isr_q & end_of_interrupt;
        eoi_idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (eoi_hit[i]) eoi_idx = 3'(i);
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        int_d   = int_q;
        vld_d   = vld_q;
        isr_d   = isr_q & ~end_of_interrupt;
        rot_d   = rot_q;

        case (state_q)
            S_IDLE: begin
                if (|eligible) state_d = S_RESOLVE;
            end
            S_RESOLVE: begin
                if (|eligible) begin
                    int_d   = winner;
                    vld_d   = 1'b1;
                    state_d = S_PRESENT;
                end else begin
                    int_d   = 8'h00;
                    vld_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            S_PRESENT: begin
                if (latch_in_service) begin
                    // EOI clear already folded into isr_d, so a same-bit set wins.
                    isr_d   = isr_d | int_q;
                    int_d   = 8'h00;
                    vld_d   = 1'b0;
                    state_d = S_IDLE;
                end else if (!freeze) begin
                    if ((eligible & int_q) == 8'h00) begin
                        int_d   = 8'h00;
                        vld_d   = 1'b0;
                        state_d = S_IDLE;
                    end else begin
                        int_d = winner;
                    end
                end
            end
            default: begin
                int_d   = 8'h00;
                vld_d   = 1'b0;
                state_d = S_IDLE;
            end
        endcase

`ifdef KF8259_AUTO_ROTATE_EN
        if (auto_rotate_mode && (eoi_hit != 8'h00) && ((eoi_hit & (eoi_hit - 8'd1)) == 8'h00))
            rot_d = eoi_idx;
`endif
        if (rotate_load) rot_d = priority_rotate;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            int_q   <= 8'h00;
            vld_q   <= 1'b0;
            isr_q   <= 8'h00;
            rot_q   <= ROT_RESET;
        end else begin
            state_q <= state_d;
            int_q   <= int_d;
            vld_q   <= vld_d;
            isr_q   <= isr_d;
            rot_q   <= rot_d;
        end
    end

    assign interrupt           = int_q;
    assign interrupt_valid     = vld_q;
    assign in_service_register = isr_q;

endmodule

// File: tb/tb_kf8259_in_service_sequencer.sv
// Directed bench for kf8259_in_service_sequencer; expected values are hand-derived.
module tb_kf8259_in_service_sequencer;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] irr = 8'h00;
    logic [7:0] imr = 8'h00;
    logic       smm = 1'b0;
    logic       sfnm = 1'b0;
    logic       freeze = 1'b0;
    logic       latch = 1'b0;
    logic [7:0] eoi = 8'h00;
    logic       rot_ld = 1'b0;
    logic [2:0] rot_in = 3'd0;
`ifdef KF8259_AUTO_ROTATE_EN
    logic       auto_rot = 1'b0;
`endif
    logic [7:0] intr;
    logic       intr_vld;
    logic [7:0] isr;
    logic [7:0] hlis;

    int n_chk = 0;
    int n_err = 0;

    kf8259_in_service_sequencer dut (
        .clock                      (clock),
        .reset                      (reset),
        .interrupt_request_register (irr),
        .interrupt_mask             (imr),
        .special_mask_mode          (smm),
        .special_fully_nest_config  (sfnm),
        .freeze                     (freeze),
        .latch_in_service           (latch),
        .end_of_interrupt           (eoi),
        .rotate_load                (rot_ld),
        .priority_rotate            (rot_in),
`ifdef KF8259_AUTO_ROTATE_EN
        .auto_rotate_mode           (auto_rot),
`endif
        .interrupt                  (intr),
        .interrupt_valid            (intr_vld),
        .in_service_register        (isr),
        .highest_level_in_service   (hlis)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        #1 reset = 1'b1;
        #2;
        chk("rst_int", 32'(intr), 32'h00);
        chk("rst_vld", 32'(intr_vld), 32'h0);
        chk("rst_isr", 32'(isr), 32'h00);
        chk("rst_hlis", 32'(hlis), 32'h00);
        tick();
        tick();
        reset = 1'b0;

        // basic resolve, two-clock latency
        irr = 8'h05;
        tick();
        chk("lat_vld_early", 32'(intr_vld), 32'h0);
        tick();
        chk("basic_int", 32'(intr), 32'h01);
        chk("basic_vld", 32'(intr_vld), 32'h1);

        // acknowledge IR0; IR2 is blocked by it
        latch = 1'b1; irr = 8'h04;
        tick();
        latch = 1'b0;
        chk("ack_isr", 32'(isr), 32'h01);
        chk("ack_int", 32'(intr), 32'h00);
        chk("ack_hlis", 32'(hlis), 32'h01);
        tick();
        tick();
        chk("blk_vld", 32'(intr_vld), 32'h0);

        // EOI releases IR2
        eoi = 8'h01;
        tick();
        eoi = 8'h00;
        chk("eoi_isr", 32'(isr), 32'h00);
        tick();
        tick();
        chk("eoi_int", 32'(intr), 32'h04);
        chk("eoi_vld", 32'(intr_vld), 32'h1);

        // freeze holds the presented winner
        freeze = 1'b1; irr = 8'h00;
        tick();
        chk("frz_int1", 32'(intr), 32'h04);
        tick();
        chk("frz_int2", 32'(intr), 32'h04);
        chk("frz_vld", 32'(intr_vld), 32'h1);
        freeze = 1'b0;
        tick();
        chk("unfrz_int", 32'(intr), 32'h00);
        chk("unfrz_vld", 32'(intr_vld), 32'h0);

        // rotation: lowest = IR3, order IR4..IR7, IR0..IR3
        rot_ld = 1'b1; rot_in = 3'd3;
        tick();
        rot_ld = 1'b0; irr = 8'h09;
        tick();
        tick();
        chk("rot_int", 32'(intr), 32'h01);
        irr = 8'h19;
        tick();
        chk("preempt_int", 32'(intr), 32'h10);
        latch = 1'b1;
        tick();
        latch = 1'b0;
        chk("rot_isr", 32'(isr), 32'h10);
        chk("rot_hlis", 32'(hlis), 32'h10);
        tick();
        tick();
        chk("rot_blk_vld", 32'(intr_vld), 32'h0);
        irr = 8'h00; eoi = 8'h10; rot_ld = 1'b1; rot_in = 3'd7;
        tick();
        eoi = 8'h00; rot_ld = 1'b0;
        chk("rot_eoi_isr", 32'(isr), 32'h00);

        // SFNM nesting and same-cycle EOI+latch
        irr = 8'h02;
        tick();
        tick();
        chk("sf_int", 32'(intr), 32'h02);
        latch = 1'b1;
        tick();
        latch = 1'b0;
        chk("sf_isr", 32'(isr), 32'h02);
        tick();
        tick();
        chk("sf_off_vld", 32'(intr_vld), 32'h0);
        sfnm = 1'b1;
        tick();
        tick();
        chk("sf_on_int", 32'(intr), 32'h02);
        chk("sf_on_vld", 32'(intr_vld), 32'h1);
        latch = 1'b1; eoi = 8'h02;
        tick();
        latch = 1'b0; eoi = 8'h00;
        chk("eoi_latch_isr", 32'(isr), 32'h02);
        chk("eoi_latch_vld", 32'(intr_vld), 32'h0);
        sfnm = 1'b0; irr = 8'h00; eoi = 8'h02;
        tick();
        eoi = 8'h00;
        chk("sf_clr_isr", 32'(isr), 32'h00);

        // special mask mode
        irr = 8'h01;
        tick();
        tick();
        chk("smm_int0", 32'(intr), 32'h01);
        latch = 1'b1; irr = 8'h02; imr = 8'h01;
        tick();
        latch = 1'b0;
        chk("smm_isr", 32'(isr), 32'h01);
        tick();
        tick();
        chk("smm_off_vld", 32'(intr_vld), 32'h0);
        smm = 1'b1;
        tick();
        tick();
        chk("smm_on_int", 32'(intr), 32'h02);

        // EOI of IR0; with auto-rotate IR1 becomes highest, otherwise IR0 preempts
`ifdef KF8259_AUTO_ROTATE_EN
        auto_rot = 1'b1;
`endif
        eoi = 8'h01;
        tick();
        eoi = 8'h00;
        chk("ar_isr", 32'(isr), 32'h00);
        imr = 8'h00; smm = 1'b0; irr = 8'h03;
        tick();
`ifdef KF8259_AUTO_ROTATE_EN
        chk("ar_int", 32'(intr), 32'h02);
        auto_rot = 1'b0;
`else
        chk("ar_int", 32'(intr), 32'h01);
`endif
        chk("ar_vld", 32'(intr_vld), 32'h1);

        // asynchronous reset mid-presentation restores rot as well
        #2 reset = 1'b1;
        #1;
        chk("async_int", 32'(intr), 32'h00);
        chk("async_vld", 32'(intr_vld), 32'h0);
        tick();
        reset = 1'b0;
        tick();
        tick();
        chk("post_rst_int", 32'(intr), 32'h01);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
